// File: rtl/cache_axi_rd_arbiter.sv
// Shares one AXI read channel between icache/dcache refills; define ARB_RR_EN for round-robin, else dcache has fixed priority.
// Grant is combinational in IDLE, AR is presented from the next cycle, R beats return 1 cycle after handshake; rready is always high.
module cache_axi_rd_arbiter (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        icache_rd_req,
   input  logic [2:0]  icache_rd_type,
   input  logic [31:0] icache_rd_addr,
   output logic        icache_rd_rdy,
   output logic        icache_ret_valid,
   output logic        icache_ret_last,
   output logic [31:0] icache_ret_data,
   input  logic        dcache_rd_req,
   input  logic [2:0]  dcache_rd_type,
   input  logic [31:0] dcache_rd_addr,
   output logic        dcache_rd_rdy,
   output logic        dcache_ret_valid,
   output logic        dcache_ret_last,
   output logic [31:0] dcache_ret_data,
   input  logic        wr_busy,
   input  logic [31:0] wr_addr,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic        proto_err
);

   localparam logic [0:0] S_IDLE     = 1'b0;
   localparam logic [0:0] S_AR_VALID = 1'b1;
   localparam logic [2:0] TYPE_LINE  = 3'b100;

   logic [0:0]  r_state;
   logic [1:0]  r_busy;
   logic [31:0] r_araddr;
   logic        r_arid_lsb;
   logic [7:0]  r_arlen;
   logic [1:0]  r_ret_valid;
   logic [1:0]  r_ret_last;
   logic [31:0] r_ret_data_i;
   logic [31:0] r_ret_data_d;
   logic        r_proto_err;

   logic        w_hazard_i, w_hazard_d;
   logic        w_elig_i, w_elig_d;
   logic        w_idle, w_pick_d;
   logic        w_grant_i, w_grant_d, w_grant;
   logic [31:0] w_gnt_addr;
   logic [2:0]  w_gnt_type;
   logic        w_r_hs, w_r_sel, w_r_ok, w_r_acc;
   logic [1:0]  w_busy_clr, w_busy_set;
   logic        w_unused;

   assign w_hazard_i = wr_busy & (wr_addr[31:4] == icache_rd_addr[31:4]);
   assign w_hazard_d = wr_busy & (wr_addr[31:4] == dcache_rd_addr[31:4]);
   assign w_elig_i   = icache_rd_req & ~r_busy[0] & ~w_hazard_i;
   assign w_elig_d   = dcache_rd_req & ~r_busy[1] & ~w_hazard_d;
   assign w_idle     = aresetn & (r_state == S_IDLE);

`ifdef ARB_RR_EN
   logic r_last_win_d;

   // On a tie the cache that won last time yields; reset state favours dcache.
   assign w_pick_d = w_elig_d & (~w_elig_i | ~r_last_win_d);

   always_ff @(posedge aclk) begin
      if (!aresetn)
         r_last_win_d <= 1'b0;
      else if (w_grant)
         r_last_win_d <= w_grant_d;
   end
`else
   assign w_pick_d = w_elig_d;
`endif

   assign w_grant_d  = w_idle & w_pick_d;
   assign w_grant_i  = w_idle & w_elig_i & ~w_pick_d;
   assign w_grant    = w_grant_d | w_grant_i;
   assign w_gnt_addr = w_pick_d ? dcache_rd_addr : icache_rd_addr;
   assign w_gnt_type = w_pick_d ? dcache_rd_type : icache_rd_type;

   // Beats for an ID with nothing outstanding, or with upper ID bits set, are dropped and flagged.
   assign w_r_hs     = rvalid & rready;
   assign w_r_sel    = rid[0];
   assign w_r_ok     = (rid[3:1] == 3'b000) & r_busy[w_r_sel];
   assign w_r_acc    = w_r_hs & w_r_ok;
   assign w_busy_clr = {2{w_r_acc & rlast}} & {w_r_sel, ~w_r_sel};
   assign w_busy_set = {w_grant_d, w_grant_i};

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state      <= S_IDLE;
         r_busy       <= 2'b00;
         r_araddr     <= 32'h0;
         r_arid_lsb   <= 1'b0;
         r_arlen      <= 8'h0;
         r_ret_valid  <= 2'b00;
         r_ret_last   <= 2'b00;
         r_ret_data_i <= 32'h0;
         r_ret_data_d <= 32'h0;
         r_proto_err  <= 1'b0;
      end else begin
         r_busy <= (r_busy & ~w_busy_clr) | w_busy_set;
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_araddr   <= w_gnt_addr;
                  r_arid_lsb <= w_grant_d;
                  r_arlen    <= (w_gnt_type == TYPE_LINE) ? 8'd3 : 8'd0;
                  r_state    <= S_AR_VALID;
               end
            end
            default: begin
               if (arready)
                  r_state <= S_IDLE;
            end
         endcase
         r_ret_valid <= {w_r_acc & w_r_sel, w_r_acc & ~w_r_sel};
         r_ret_last  <= {w_r_acc & w_r_sel & rlast, w_r_acc & ~w_r_sel & rlast};
         if (w_r_acc & ~w_r_sel)
            r_ret_data_i <= rdata;
         if (w_r_acc & w_r_sel)
            r_ret_data_d <= rdata;
         if (w_r_hs & ~w_r_ok)
            r_proto_err <= 1'b1;
      end
   end

   assign icache_rd_rdy    = w_grant_i;
   assign dcache_rd_rdy    = w_grant_d;
   assign icache_ret_valid = r_ret_valid[0];
   assign dcache_ret_valid = r_ret_valid[1];
   assign icache_ret_last  = r_ret_last[0];
   assign dcache_ret_last  = r_ret_last[1];
   assign icache_ret_data  = r_ret_data_i;
   assign dcache_ret_data  = r_ret_data_d;

   assign arvalid   = (r_state == S_AR_VALID);
   assign araddr    = r_araddr;
   assign arid      = {3'b000, r_arid_lsb};
   assign arlen     = r_arlen;
   assign arsize    = 3'b010;
   assign arburst   = 2'b01;
   assign arlock    = 2'b00;
   assign arcache   = 4'b0000;
   assign arprot    = 3'b000;
   assign rready    = aresetn;
   assign proto_err = r_proto_err;

   assign w_unused = ^{rresp, wr_addr[3:0]};

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Randomized bench: cache requesters, write-path hazards and an AXI read slave driven against a transaction-level model.
module tb_cache_axi_rd_arbiter;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        icache_rd_req, dcache_rd_req;
   logic [2:0]  icache_rd_type, dcache_rd_type;
   logic [31:0] icache_rd_addr, dcache_rd_addr;
   logic        icache_rd_rdy, dcache_rd_rdy;
   logic        icache_ret_valid, dcache_ret_valid;
   logic        icache_ret_last, dcache_ret_last;
   logic [31:0] icache_ret_data, dcache_ret_data;
   logic        wr_busy;
   logic [31:0] wr_addr;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst, arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;
   logic        proto_err;

   always #5 aclk = ~aclk;

   cache_axi_rd_arbiter dut (
      .aclk(aclk), .aresetn(aresetn),
      .icache_rd_req(icache_rd_req), .icache_rd_type(icache_rd_type), .icache_rd_addr(icache_rd_addr),
      .icache_rd_rdy(icache_rd_rdy), .icache_ret_valid(icache_ret_valid), .icache_ret_last(icache_ret_last),
      .icache_ret_data(icache_ret_data),
      .dcache_rd_req(dcache_rd_req), .dcache_rd_type(dcache_rd_type), .dcache_rd_addr(dcache_rd_addr),
      .dcache_rd_rdy(dcache_rd_rdy), .dcache_ret_valid(dcache_ret_valid), .dcache_ret_last(dcache_ret_last),
      .dcache_ret_data(dcache_ret_data),
      .wr_busy(wr_busy), .wr_addr(wr_addr),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
      .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .proto_err(proto_err)
   );

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model state: what is outstanding per cache, the AR currently being offered, and the slave's remaining beats.
   logic [1:0]  m_busy;
   bit          m_ar_pend;
   logic [31:0] m_araddr;
   logic [7:0]  m_arlen;
   logic [3:0]  m_arid;
   bit          m_last_d;
   bit          m_err;
   logic [1:0]  exp_rv, exp_rl;
   logic [31:0] exp_rd [2];
   int          slave_rem [2];
   bit          gi, gd, drop_i, drop_d;
   int          bx, r;

   task automatic model_reset();
      m_busy = 2'b00; m_ar_pend = 0; m_araddr = 32'h0; m_arlen = 8'h0; m_arid = 4'h0;
      m_last_d = 0; m_err = 0; exp_rv = 2'b00; exp_rl = 2'b00;
      exp_rd[0] = 32'h0; exp_rd[1] = 32'h0; slave_rem[0] = 0; slave_rem[1] = 0;
   endtask

   function automatic bit hazard(input logic [31:0] a);
      return wr_busy && (wr_addr[31:4] == a[31:4]);
   endfunction

   task automatic compute_grant();
      bit ei, ed, pick_d;
      gi = 0; gd = 0;
      if (aresetn && !m_ar_pend) begin
         ei = icache_rd_req && !m_busy[0] && !hazard(icache_rd_addr);
         ed = dcache_rd_req && !m_busy[1] && !hazard(dcache_rd_addr);
`ifdef ARB_RR_EN
         pick_d = ed && (!ei || !m_last_d);
`else
         pick_d = ed;
`endif
         gd = pick_d;
         gi = ei && !pick_d;
      end
   endtask

   task automatic drive_inputs(input bit rst);
      aresetn = !rst;
      if (drop_i) icache_rd_req = 0;
      if (drop_d) dcache_rd_req = 0;
      drop_i = 0; drop_d = 0;
      if (!icache_rd_req && $urandom_range(0, 99) < 30) begin
         icache_rd_req  = 1;
         icache_rd_type = $urandom_range(0, 1) ? 3'b100 : 3'($urandom_range(0, 7));
         icache_rd_addr = 32'h1C00_0000 + $urandom_range(0, 1023);
      end
      if (!dcache_rd_req && $urandom_range(0, 99) < 30) begin
         dcache_rd_req  = 1;
         dcache_rd_type = $urandom_range(0, 1) ? 3'b100 : 3'($urandom_range(0, 7));
         dcache_rd_addr = 32'h1C00_0000 + $urandom_range(0, 1023);
      end
      wr_busy = ($urandom_range(0, 99) < 35);
      if ($urandom_range(0, 1))
         wr_addr = {($urandom_range(0, 1) ? dcache_rd_addr[31:4] : icache_rd_addr[31:4]), 4'($urandom_range(0, 15))};
      else
         wr_addr = 32'h1C00_0000 + $urandom_range(0, 1023);
      arready = ($urandom_range(0, 99) < 60);
      rvalid = 0; rid = 4'h0; rlast = 0;
      rdata  = $urandom; rresp = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 99);
      if (r < 45 && (slave_rem[0] > 0 || slave_rem[1] > 0)) begin
         if (slave_rem[0] > 0 && slave_rem[1] > 0) bx = $urandom_range(0, 1);
         else bx = (slave_rem[1] > 0) ? 1 : 0;
         rvalid = 1; rid = 4'(bx); rlast = (slave_rem[bx] == 1);
      end else if (r >= 97) begin
         rvalid = 1; rlast = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 0 && !m_busy[0])      rid = 4'd0;
         else if ($urandom_range(0, 1) == 0 && !m_busy[1]) rid = 4'd1;
         else                                              rid = 4'($urandom_range(2, 15));
      end
   endtask

   task automatic check_outputs();
      check_eq("icache_rd_rdy", icache_rd_rdy, gi);
      check_eq("dcache_rd_rdy", dcache_rd_rdy, gd);
      check_eq("arvalid", arvalid, m_ar_pend);
      check_eq("araddr", araddr, m_araddr);
      check_eq("arlen", arlen, m_arlen);
      check_eq("arid", arid, m_arid);
      check_eq("ar_fixed", {arsize, arburst, arlock, arcache, arprot}, {3'b010, 2'b01, 2'b00, 4'h0, 3'h0});
      check_eq("rready", rready, aresetn);
      check_eq("icache_ret_valid", icache_ret_valid, exp_rv[0]);
      check_eq("dcache_ret_valid", dcache_ret_valid, exp_rv[1]);
      check_eq("icache_ret_last", icache_ret_last, exp_rl[0]);
      check_eq("dcache_ret_last", dcache_ret_last, exp_rl[1]);
      check_eq("icache_ret_data", icache_ret_data, exp_rd[0]);
      check_eq("dcache_ret_data", dcache_ret_data, exp_rd[1]);
      check_eq("proto_err", proto_err, m_err);
   endtask

   // Advance the model across one rising edge using the values the DUT sampled.
   task automatic model_step();
      int x;
      if (!aresetn) begin
         model_reset();
         return;
      end
      exp_rv = 2'b00; exp_rl = 2'b00;
      if (rvalid) begin
         x = rid[0];
         if (rid[3:1] == 3'b000 && m_busy[x]) begin
            exp_rv[x] = 1; exp_rl[x] = rlast; exp_rd[x] = rdata;
            slave_rem[x]--;
            if (rlast) m_busy[x] = 0;
         end else begin
            m_err = 1;
         end
      end
      if (m_ar_pend) begin
         if (arready) begin
            slave_rem[m_arid[0]] = int'(m_arlen) + 1;
            m_ar_pend = 0;
         end
      end else if (gi || gd) begin
         m_ar_pend = 1;
         m_arid    = gd ? 4'd1 : 4'd0;
         m_araddr  = gd ? dcache_rd_addr : icache_rd_addr;
         m_arlen   = ((gd ? dcache_rd_type : icache_rd_type) == 3'b100) ? 8'd3 : 8'd0;
         m_busy[gd ? 1 : 0] = 1;
         m_last_d  = gd;
         if (gd) drop_d = 1; else drop_i = 1;
      end
   endtask

   initial begin
      aresetn = 0; icache_rd_req = 0; dcache_rd_req = 0;
      icache_rd_type = 3'b0; dcache_rd_type = 3'b0;
      icache_rd_addr = 32'h0; dcache_rd_addr = 32'h0;
      wr_busy = 0; wr_addr = 32'h0; arready = 0;
      rid = 4'h0; rdata = 32'h0; rresp = 2'b0; rlast = 0; rvalid = 0;
      drop_i = 0; drop_d = 0;
      model_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge aclk);
         drive_inputs((cyc < 2) || (cyc >= 1200 && cyc < 1202) || (cyc == 2400));
         #2;
         compute_grant();
         check_outputs();
         @(posedge aclk);
         model_step();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cache_axi_rd_arbiter.md
# cache_axi_rd_arbiter

Shares the single AXI read address/data channel between the instruction cache and the data cache refill ports. It arbitrates requests, issues AR transactions tagged by requester ID, and routes R beats back to the owning cache with registered valid/last/data. A write-hazard check blocks a read that targets a line still being written. The block sits between the two caches and the AXI write/read bridge.

## Interface
- No parameters; data width fixed at 32, line size 16 bytes (4 beats).
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- icache_rd_req / dcache_rd_req  in  1  refill request; held with type/addr until matching rd_rdy
- icache_rd_type / dcache_rd_type  in  3  3'b100 = line (4 beats), else single word
- icache_rd_addr / dcache_rd_addr  in  32  byte address
- icache_rd_rdy / dcache_rd_rdy  out  1  request accepted this cycle
- icache_ret_valid / dcache_ret_valid  out  1  returned beat valid
- icache_ret_last / dcache_ret_last  out  1  final beat of transaction
- icache_ret_data / dcache_ret_data  out  32  returned beat data
- wr_busy  in  1  write transaction outstanding in write path
- wr_addr  in  32  address of outstanding write
- arid  out  4 / araddr  out  32 / arlen  out  8 / arsize  out  3 / arburst  out  2 / arlock  out  2 / arcache  out  4 / arprot  out  3 / arvalid  out  1 / arready  in  1
- rid  in  4 / rdata  in  32 / rresp  in  2 / rlast  in  1 / rvalid  in  1 / rready  out  1
- proto_err  out  1  sticky: R beat with rid not outstanding

## Operation
- AR FSM, states IDLE, AR_VALID.
- IDLE: eligible requester = req high, its busy flag clear, and not hazard-blocked. Hazard-blocked = wr_busy & (wr_addr[31:4] == rd_addr[31:4]). Winner selected per arbitration policy (see Configuration). Winner's rd_rdy asserts combinationally; araddr/arlen/arid registered; busy[id] set; go AR_VALID.
- AR_VALID: arvalid=1, fields stable; arready -> IDLE.
- arid = {3'b0, id}, dcache id 1, icache id 0. arlen = 8'd3 for line type, else 8'd0. arsize 3'b010, arburst 2'b01, arlock/arcache/arprot 0.
- At most one outstanding transaction per ID; a second request from the same cache waits until its busy flag clears.
- rready = 1 whenever out of reset.
- R beat (rvalid & rready): rid[0] selects the cache. The next cycle, ret_valid = 1, ret_data = rdata, ret_last = rlast for that cache only. A beat with rlast clears busy[rid[0]].
- A beat whose ID has its busy flag clear, or with rid[3:1] != 0, is dropped (no ret_valid) and sets proto_err. rresp is ignored.

## Timing
- Reset values: arvalid 0, araddr 0, arid 0, arlen 0, rready 0, both rd_rdy 0, all ret_valid/ret_last 0, ret_data 0, proto_err 0, busy flags 0, FSM IDLE.
- Accept at cycle T (rd_rdy=1); arvalid=1 from T+1; arready at T+1 -> IDLE at T+2. Sustained rate: one AR per 2 cycles.
- Return latency: exactly 1 cycle from R handshake to ret_valid.
- Beats arriving while AR FSM busy are routed normally; AR and R paths are independent.
- Same cycle rlast clears busy[x] and cache x requests: not eligible until next cycle (busy is registered).
- A write hazard raised in the same cycle as an IDLE grant blocks that grant.
- Reset mid-transaction: all state cleared immediately; in-flight beats after reset with busy clear set proto_err.

## Configuration
- ARB_RR_EN defined: round-robin. The last winner has lowest priority on the next simultaneous request; the pointer resets to favour dcache.
- Undefined: fixed priority, dcache over icache always.

## Test plan
- icache line req addr 0x1C000010 alone, arready=1 -> araddr 0x1C000010, arlen 3, arid 0; 4 beats rid 0 -> 4 icache_ret_valid, last on 4th, 1-cycle lag.
- Both request simultaneously, twice -> fixed: dcache first then icache; ARB_RR_EN: dcache, icache, then icache wins round 2 if dcache was last.
- wr_busy=1, wr_addr 0x00001234, dcache rd 0x00001238 -> no dcache_rd_rdy until wr_busy falls; icache rd 0x00002000 is granted meanwhile.
- Interleaved R beats rid 1, 0, 1 -> routed to dcache, icache, dcache with no cross-assertion.
- Beat with rid 0 while icache not busy -> no ret_valid, proto_err=1 and held until reset.
- aresetn low during AR_VALID -> arvalid 0 next cycle, busy cleared, new request accepted after release.
